mprj_cfg_seq: RTL and testbench
===============================

# mprj_cfg_seq

Boot-time GPIO configuration sequencer and bus arbiter sitting between the management CPU's Wishbone master and the user-project control slave (GPIO config/xfer registers at BASE_ADR). On a start pulse it takes over the slave port and writes one control word per pad from an external config table. It then triggers the serial loader and polls its busy flag to completion. Outside a sequence it passes CPU traffic straight through.

## Interface
- BASE_ADR, 32'h2300_0000, slave base address; the full address is issued on m_adr_o.
- XFER, 8'h00, offset of the transfer-control/busy register.
- IOCONFIG, 8'h20, offset of pad 0 control word; pad i is at IOCONFIG+4*i.
- NUM_PADS, 38, number of pad control words written (1..64).
- IO_CTRL_BITS, 13, width of one pad control word.
- POLL_LIMIT, 16'd4095, maximum busy polls before abort.
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to run a sequence
- busy  out  1  high from the accepted start until the done pulse
- done  out  1  one-cycle pulse when the sequence ends
- error  out  1  sticky poll timeout; cleared by the next accepted start
- cfg_idx  out  6  table index requested; combinational table lookup
- cfg_data  in  IO_CTRL_BITS  control word for cfg_idx, sampled in the same cycle
- cpu_cyc_i, cpu_stb_i, cpu_we_i  in  1 each  CPU Wishbone controls
- cpu_adr_i, cpu_dat_i  in  32 each; cpu_sel_i  in  4
- cpu_dat_o  out  32; cpu_ack_o  out  1
- m_cyc_o, m_stb_o, m_we_o  out  1 each; m_adr_o, m_dat_o  out  32; m_sel_o  out  4
- m_dat_i  in  32; m_ack_i  in  1  from the control slave

## Operation
- States: IDLE, WAIT_BUS, WR_CFG, WR_XFER, POLL, FINISH.
- IDLE and WAIT_BUS: all m_* outputs mirror the cpu_* inputs combinationally. cpu_ack_o = m_ack_i and cpu_dat_o = m_dat_i.
- IDLE, start=1: clear error, set busy, reset cfg_idx to 0.
  - If cpu_cyc_i=0, go to WR_CFG.
  - Otherwise go to WAIT_BUS, which moves to WR_CFG on the first cycle with cpu_cyc_i=0.
- From WR_CFG until FINISH, the sequencer owns the bus. cpu_ack_o=0, cpu_dat_o=0, and CPU cycles stall.
- Sequencer access: m_cyc_o and m_stb_o are held high until m_ack_i is sampled high, followed by exactly one cycle with cyc/stb low. This gap is required because the slave rejects back-to-back strobes.
- WR_CFG:
  - m_we_o=1, m_sel_o=4'hF.
  - m_adr_o = BASE_ADR | (IOCONFIG + 4*cfg_idx).
  - m_dat_o = zero-extended cfg_data.
  - On ack: if cfg_idx = NUM_PADS-1 go to WR_XFER, else cfg_idx+1.
- WR_XFER: write 32'h1 to BASE_ADR|XFER. On ack, clear poll_cnt and go to POLL.
- POLL: read BASE_ADR|XFER (m_we_o=0, sel 4'hF). On ack:
  - If m_dat_i[0]=0, go to FINISH.
  - Else if poll_cnt = POLL_LIMIT-1, set error and go to FINISH.
  - Else poll_cnt+1 and repeat after the gap cycle.
- FINISH: release the bus, pulse done, clear busy, return to IDLE.
- start while busy=1 is ignored, with no queuing.
- A CPU cycle already in flight when start arrives completes normally via pass-through.

## Timing
- Reset values: busy=0, done=0, error=0, cfg_idx=0, state IDLE. m_* follow cpu_* (pass-through), so they are 0 when the CPU is idle.
- Start to first m_stb_o: 1 cycle when the bus is free.
- Each access occupies 3 cycles against a 1-cycle registered-ack slave: strobe, ack, gap.
- Write phase: 3*(NUM_PADS+1) cycles.
- The first poll strobe rises at least 2 cycles after the XFER ack, so busy is already visible.
- The done pulse occurs in the FINISH cycle. busy falls in the same cycle as done.
- Reset mid-sequence: immediate return to IDLE with bus released. No done pulse. Partially written pads are not repaired.
- poll_cnt is 16 bits and saturates at POLL_LIMIT.
- cfg_idx never exceeds NUM_PADS-1.

## Structure
- Package mprj_cfg_pkg holds:
  - state encoding localparams
  - the XFER/IOCONFIG default offsets
  - the access-gap length constant
- Sub-module mprj_wb_xact: a single-access Wishbone master engine.
  - Inputs: req, we, adr, dat.
  - Behaviour: strobe/ack/gap handling.
  - Outputs: the ack_done pulse and rdata.
- The top level contains the FSM, counters and the pass-through mux.

## Test plan
- Full sequence, NUM_PADS=38, cfg_data = 0x1803 for idx 0..1 and 0x0403 otherwise, slave model busy for 20 polls:
  - 38 writes to 0x2300_0020..0x2300_00B4 with the correct data.
  - Write 0x1 to 0x2300_0000.
  - 21 polls, then done=1 for 1 cycle with error=0.
- start while a CPU read of 0x2300_0008 is pending:
  - The CPU read completes with its data.
  - The first sequencer strobe appears only after cpu_cyc_i falls.
- CPU write issued mid-sequence: cpu_ack_o stays 0 until FINISH. The write then passes through and acks in IDLE.
- Slave busy stuck at 1, POLL_LIMIT=8: exactly 8 polls, then error=1 and done pulses. The next start clears error.
- resetn asserted during write 10:
  - Outputs reset asynchronously and busy=0.
  - A new start restarts at address 0x2300_0020.
- start pulsed again while busy: ignored. The sequence count, write count and done pulse count are unchanged (1 done).

Source files
------------

// File: rtl/mprj_cfg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mprj_cfg_pkg : shared constants and state encoding for the GPIO config sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
package mprj_cfg_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_BUS = 3'd1;
    localparam logic [2:0] ST_WR_CFG   = 3'd2;
    localparam logic [2:0] ST_WR_XFER  = 3'd3;
    localparam logic [2:0] ST_POLL     = 3'd4;
    localparam logic [2:0] ST_FINISH   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_WAIT_BUS = ST_WAIT_BUS,
        S_WR_CFG   = ST_WR_CFG,
        S_WR_XFER  = ST_WR_XFER,
        S_POLL     = ST_POLL,
        S_FINISH   = ST_FINISH
    } state_t;

    localparam logic [7:0] XFER_OFS     = 8'h00;
    localparam logic [7:0] IOCONFIG_OFS = 8'h20;

    // Idle cycles forced after each acked access; the slave rejects back-to-back strobes.
    localparam logic [1:0] ACC_GAP = 2'd1;

    function automatic logic [31:0] reg_adr(input logic [31:0] base, input logic [31:0] ofs);
        return base | ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mprj_wb_xact.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mprj_wb_xact : single-access Wishbone master with a forced idle gap after ack
// Revision 1.0
// ----------------------------------------------------------------------------
module mprj_wb_xact
    import mprj_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        ack_done_o,
    output logic [31:0] rdata_o
);

    logic [1:0] gap_q;
    logic [1:0] gap_d;
    logic       w_active;

    assign w_active   = req_i && (gap_q == 2'd0);
    assign cyc_o      = w_active;
    assign stb_o      = w_active;
    assign we_o       = w_active && we_i;
    assign adr_o      = w_active ? adr_i : 32'h0;
    assign dat_o      = w_active ? dat_i : 32'h0;
    assign sel_o      = w_active ? 4'hF : 4'h0;
    assign ack_done_o = w_active && m_ack_i;
    assign rdata_o    = m_dat_i;

    always_comb begin
        gap_d = gap_q;
        if (ack_done_o) begin
            gap_d = ACC_GAP;
        end else if (gap_q != 2'd0) begin
            gap_d = gap_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_q <= 2'd0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mprj_cfg_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mprj_cfg_seq : boot-time GPIO config sequencer and CPU/sequencer bus arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
module mprj_cfg_seq
    import mprj_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADR     = 32'h2300_0000,
    parameter logic [7:0]  XFER         = XFER_OFS,
    parameter logic [7:0]  IOCONFIG     = IOCONFIG_OFS,
    parameter int          NUM_PADS     = 38,
    parameter int          IO_CTRL_BITS = 13,
    parameter logic [15:0] POLL_LIMIT   = 16'd4095
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [5:0]              cfg_idx,
    input  logic [IO_CTRL_BITS-1:0] cfg_data,
    input  logic                    cpu_cyc_i,
    input  logic                    cpu_stb_i,
    input  logic                    cpu_we_i,
    input  logic [31:0]             cpu_adr_i,
    input  logic [31:0]             cpu_dat_i,
    input  logic [3:0]              cpu_sel_i,
    output logic [31:0]             cpu_dat_o,
    output logic                    cpu_ack_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [31:0]             m_adr_o,
    output logic [31:0]             m_dat_o,
    output logic [3:0]              m_sel_o,
    input  logic [31:0]             m_dat_i,
    input  logic                    m_ack_i
);

    localparam logic [5:0]  LAST_IDX = 6'(NUM_PADS - 1);
    localparam logic [31:0] XFER_ADR = reg_adr(BASE_ADR, {24'h0, XFER});

    state_t      state_q, state_d;
    logic [5:0]  cfg_idx_q, cfg_idx_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        error_q, error_d;

    logic        x_req, x_we;
    logic [31:0] x_adr, x_dat;
    logic        x_cyc, x_stb, x_we_o;
    logic [31:0] x_adr_o, x_dat_o, w_rdata;
    logic [3:0]  x_sel;
    logic        w_ack_done;
    logic        w_pass;

    mprj_wb_xact u_xact (
        .clk        (clk),
        .resetn     (resetn),
        .req_i      (x_req),
        .we_i       (x_we),
        .adr_i      (x_adr),
        .dat_i      (x_dat),
        .m_ack_i    (m_ack_i),
        .m_dat_i    (m_dat_i),
        .cyc_o      (x_cyc),
        .stb_o      (x_stb),
        .we_o       (x_we_o),
        .adr_o      (x_adr_o),
        .dat_o      (x_dat_o),
        .sel_o      (x_sel),
        .ack_done_o (w_ack_done),
        .rdata_o    (w_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cfg_idx_d  = cfg_idx_q;
        poll_cnt_d = poll_cnt_q;
        error_d    = error_q;
        x_req      = 1'b0;
        x_we       = 1'b0;
        x_adr      = XFER_ADR;
        x_dat      = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d   = 1'b0;
                    cfg_idx_d = 6'd0;
                    state_d   = cpu_cyc_i ? S_WAIT_BUS : S_WR_CFG;
                end
            end
            S_WAIT_BUS: begin
                if (!cpu_cyc_i) begin
                    state_d = S_WR_CFG;
                end
            end
            S_WR_CFG: begin
                x_req = 1'b1;
                x_we  = 1'b1;
                x_adr = reg_adr(BASE_ADR, 32'(IOCONFIG) + {24'h0, cfg_idx_q, 2'b00});
                x_dat = {{(32-IO_CTRL_BITS){1'b0}}, cfg_data};
                if (w_ack_done) begin
                    if (cfg_idx_q == LAST_IDX) begin
                        state_d = S_WR_XFER;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 6'd1;
                    end
                end
            end
            S_WR_XFER: begin
                x_req = 1'b1;
                x_we  = 1'b1;
                x_dat = 32'h1;
                if (w_ack_done) begin
                    poll_cnt_d = 16'd0;
                    state_d    = S_POLL;
                end
            end
            S_POLL: begin
                x_req = 1'b1;
                if (w_ack_done) begin
                    if (!w_rdata[0]) begin
                        state_d = S_FINISH;
                    end else if (poll_cnt_q == POLL_LIMIT - 16'd1) begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end else if (poll_cnt_q != POLL_LIMIT) begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cfg_idx_q  <= 6'd0;
            poll_cnt_q <= 16'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_idx_q  <= cfg_idx_d;
            poll_cnt_q <= poll_cnt_d;
            error_q    <= error_d;
        end
    end

    assign busy    = (state_q == S_WAIT_BUS) || (state_q == S_WR_CFG) ||
                     (state_q == S_WR_XFER)  || (state_q == S_POLL);
    assign done    = (state_q == S_FINISH);
    assign error   = error_q;
    assign cfg_idx = cfg_idx_q;
    assign w_pass  = (state_q == S_IDLE) || (state_q == S_WAIT_BUS);

    // The CPU keeps the bus whenever no sequence owns it, including while waiting for it to let go.
    always_comb begin
        m_cyc_o   = x_cyc;
        m_stb_o   = x_stb;
        m_we_o    = x_we_o;
        m_adr_o   = x_adr_o;
        m_dat_o   = x_dat_o;
        m_sel_o   = x_sel;
        cpu_ack_o = 1'b0;
        cpu_dat_o = 32'h0;
        if (w_pass) begin
            m_cyc_o   = cpu_cyc_i;
            m_stb_o   = cpu_stb_i;
            m_we_o    = cpu_we_i;
            m_adr_o   = cpu_adr_i;
            m_dat_o   = cpu_dat_i;
            m_sel_o   = cpu_sel_i;
            cpu_ack_o = m_ack_i;
            cpu_dat_o = w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mprj_cfg_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mprj_cfg_seq : directed bench for mprj_cfg_seq with behavioural control slaves
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mprj_cfg_seq;

    localparam logic [31:0] BASE = 32'h2300_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    // Instance A: default parameters, shared CPU port
    logic        a_start, a_busy, a_done, a_error;
    logic [5:0]  a_idx;
    logic [12:0] a_cfg;
    logic        cpu_cyc, cpu_stb, cpu_we, cpu_ack;
    logic [31:0] cpu_adr, cpu_dat, cpu_rdat;
    logic [3:0]  cpu_sel;
    logic        a_cyc, a_stb, a_we, a_ack;
    logic [31:0] a_adr, a_wdat, a_rdat;
    logic [3:0]  a_sel;

    // Instance B: two pads, poll limit 8, slave busy stuck high
    logic        b_start, b_busy, b_done, b_error;
    logic [5:0]  b_idx;
    logic        b_cpu_ack, b_cyc, b_stb, b_we, b_ack;
    logic [31:0] b_cpu_rdat, b_adr, b_wdat, b_rdat;
    logic [3:0]  b_sel;

    assign a_cfg = (a_idx < 6'd2) ? 13'h1803 : 13'h0403;

    mprj_cfg_seq dut (
        .clk(clk), .resetn(resetn), .start(a_start), .busy(a_busy), .done(a_done),
        .error(a_error), .cfg_idx(a_idx), .cfg_data(a_cfg),
        .cpu_cyc_i(cpu_cyc), .cpu_stb_i(cpu_stb), .cpu_we_i(cpu_we),
        .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_sel_i(cpu_sel),
        .cpu_dat_o(cpu_rdat), .cpu_ack_o(cpu_ack),
        .m_cyc_o(a_cyc), .m_stb_o(a_stb), .m_we_o(a_we), .m_adr_o(a_adr),
        .m_dat_o(a_wdat), .m_sel_o(a_sel), .m_dat_i(a_rdat), .m_ack_i(a_ack)
    );

    mprj_cfg_seq #(.NUM_PADS(2), .POLL_LIMIT(16'd8)) dut_b (
        .clk(clk), .resetn(resetn), .start(b_start), .busy(b_busy), .done(b_done),
        .error(b_error), .cfg_idx(b_idx), .cfg_data(13'h0AAA),
        .cpu_cyc_i(1'b0), .cpu_stb_i(1'b0), .cpu_we_i(1'b0),
        .cpu_adr_i(32'h0), .cpu_dat_i(32'h0), .cpu_sel_i(4'h0),
        .cpu_dat_o(b_cpu_rdat), .cpu_ack_o(b_cpu_ack),
        .m_cyc_o(b_cyc), .m_stb_o(b_stb), .m_we_o(b_we), .m_adr_o(b_adr),
        .m_dat_o(b_wdat), .m_sel_o(b_sel), .m_dat_i(b_rdat), .m_ack_i(b_ack)
    );

    // Slave A: registered ack, XFER busy for 20 polls after a kick, logs writes
    logic [31:0] a_wlog_adr [0:255];
    logic [31:0] a_wlog_dat [0:255];
    int          a_wn = 0, a_polls = 0, a_viol = 0, a_busy_left;
    logic        a_ack_last;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_ack       <= 1'b0;
            a_rdat      <= 32'h0;
            a_busy_left <= 0;
            a_ack_last  <= 1'b0;
        end else begin
            a_ack_last <= a_ack;
            if (a_ack_last && a_stb) a_viol <= a_viol + 1;
            a_ack <= a_cyc && a_stb && !a_ack;
            if (a_cyc && a_stb && !a_ack) begin
                if (a_we) begin
                    a_wlog_adr[a_wn[7:0]] <= a_adr;
                    a_wlog_dat[a_wn[7:0]] <= a_wdat;
                    a_wn <= a_wn + 1;
                    if (a_adr == BASE && a_wdat[0]) a_busy_left <= 20;
                end else if (a_adr == BASE) begin
                    a_polls <= a_polls + 1;
                    a_rdat  <= {31'b0, a_busy_left != 0};
                    if (a_busy_left != 0) a_busy_left <= a_busy_left - 1;
                end else begin
                    a_rdat <= {16'hCAFE, a_adr[15:0]};
                end
            end
        end
    end

    int b_wn = 0, b_polls = 0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_ack  <= 1'b0;
            b_rdat <= 32'h0;
        end else begin
            b_ack <= b_cyc && b_stb && !b_ack;
            if (b_cyc && b_stb && !b_ack) begin
                if (b_we) b_wn <= b_wn + 1;
                else begin
                    b_polls <= b_polls + 1;
                    b_rdat  <= 32'h1;
                end
            end
        end
    end

    int n_asserts = 0;
    int n_fails   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the first sequence cycle; optionally re-pulses start and launches a CPU write.
    task automatic run_a(input int restart_at, input int cpu_wr_at, output int lat,
                         output int ndone, output int nack, output logic busy_d, output logic err_d);
        lat = 1; ndone = 0; nack = 0; busy_d = 1'b1; err_d = 1'b1;
        while (ndone == 0 && lat < 3000) begin
            @(negedge clk);
            lat++;
            a_start = (lat == restart_at);
            if (lat == cpu_wr_at) begin
                cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b1;
                cpu_adr = BASE + 32'h10; cpu_dat = 32'h55; cpu_sel = 4'hF;
            end
            if (cpu_ack) nack++;
            if (a_done) begin
                ndone++;
                busy_d = a_busy;
                err_d  = a_error;
            end
        end
        a_start = 1'b0;
        check_val("seq_done_seen", ndone, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ndone, nack, base, pbase, bad, k;
        logic bd, ed;
        resetn = 1'b0; a_start = 1'b0; b_start = 1'b0;
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        cpu_adr = 32'h0; cpu_dat = 32'h0; cpu_sel = 4'h0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_error", a_error, 0);
        check_val("rst_idx", a_idx, 0);
        check_val("rst_m_cyc", a_cyc, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Full sequence with a redundant start pulse while busy
        base = a_wn; pbase = a_polls;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_val("t1_busy", a_busy, 1);
        check_val("t1_first_stb", a_stb, 1);
        check_val("t1_first_adr", a_adr, BASE + 32'h20);
        check_val("t1_first_dat", a_wdat, 32'h1803);
        run_a(30, -1, lat, ndone, nack, bd, ed);
        check_val("t1_latency", lat, 180);
        check_val("t1_busy_at_done", bd, 0);
        check_val("t1_error", ed, 0);
        repeat (5) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        check_val("t1_done_count", ndone, 1);
        check_val("t1_writes", a_wn - base, 39);
        bad = 0;
        for (int i = 0; i < 38; i++) begin
            if (a_wlog_adr[base + i] !== BASE + 32'h20 + 32'(4 * i)) bad++;
            if (a_wlog_dat[base + i] !== ((i < 2) ? 32'h1803 : 32'h0403)) bad++;
        end
        check_val("t1_cfg_writes_bad", bad, 0);
        check_val("t1_xfer_adr", a_wlog_adr[base + 38], BASE);
        check_val("t1_xfer_dat", a_wlog_dat[base + 38], 32'h1);
        check_val("t1_polls", a_polls - pbase, 21);
        check_val("t1_gap_violations", a_viol, 0);

        // Start while a CPU read is in flight
        base = a_wn;
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = BASE + 32'h8; cpu_sel = 4'hF;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_val("t2_busy", a_busy, 1);
        check_val("t2_cpu_ack", cpu_ack, 1);
        check_val("t2_cpu_rdat", cpu_rdat, 32'hCAFE_0008);
        @(negedge clk);
        check_val("t2_still_cpu_adr", a_adr, BASE + 32'h8);
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        @(negedge clk);
        check_val("t2_seq_stb", a_stb, 1);
        check_val("t2_seq_adr", a_adr, BASE + 32'h20);
        run_a(-1, -1, lat, ndone, nack, bd, ed);
        check_val("t2_error", ed, 0);
        check_val("t2_writes", a_wn - base, 39);
        check_val("t2_gap_violations", a_viol, 0);
        @(negedge clk);

        // CPU write issued mid-sequence stalls until the sequence ends
        base = a_wn;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        run_a(-1, 20, lat, ndone, nack, bd, ed);
        check_val("t3_cpu_ack_during_seq", nack, 0);
        check_val("t3_seq_writes", a_wn - base, 39);
        k = 0;
        while (!cpu_ack && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_val("t3_cpu_ack_delay", k, 2);
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check_val("t3_total_writes", a_wn - base, 40);
        check_val("t3_cpu_wr_adr", a_wlog_adr[base + 39], BASE + 32'h10);
        check_val("t3_cpu_wr_dat", a_wlog_dat[base + 39], 32'h55);

        // Poll timeout on the stuck slave, then error cleared by the next start
        for (int pass = 0; pass < 2; pass++) begin
            base = b_wn; pbase = b_polls;
            b_start = 1'b1;
            @(negedge clk);
            b_start = 1'b0;
            check_val("t4_error_cleared", b_error, 0);
            check_val("t4_busy", b_busy, 1);
            k = 0;
            while (!b_done && k < 500) begin
                @(negedge clk);
                k++;
            end
            check_val("t4_done", b_done, 1);
            check_val("t4_busy_at_done", b_busy, 0);
            check_val("t4_polls", b_polls - pbase, 8);
            check_val("t4_writes", b_wn - base, 3);
            @(negedge clk);
            check_val("t4_error_sticky", b_error, 1);
            check_val("t4_done_single", b_done, 0);
        end

        // Asynchronous reset during write 10, then a clean restart
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        k = 0;
        while (!(a_stb && a_adr == BASE + 32'h48) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("t5_reached_write10", a_adr, BASE + 32'h48);
        resetn = 1'b0;
        #1;
        check_val("t5_busy", a_busy, 0);
        check_val("t5_stb", a_stb, 0);
        check_val("t5_cyc", a_cyc, 0);
        check_val("t5_idx", a_idx, 0);
        check_val("t5_done", a_done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        base = a_wn;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_val("t5_restart_adr", a_adr, BASE + 32'h20);
        check_val("t5_restart_stb", a_stb, 1);
        run_a(-1, -1, lat, ndone, nack, bd, ed);
        check_val("t5_latency", lat, 180);
        check_val("t5_error", ed, 0);
        check_val("t5_writes", a_wn - base, 39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
